// File: rtl/nanorv32_pkg.sv
// Shared nanorv32 definitions: memory-port arbiter states and system address map.
package nanorv32_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HPEND  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_t;

  // RAM occupies the low region; MMIO is selected by address bit 31.
  localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
  localparam logic [31:0] RAM_BYTES    = 32'h0001_0000;
  localparam logic [31:0] MMIO_BASE    = 32'h8000_0000;
  localparam logic [31:0] INPORT_ADDR  = 32'h8000_0000;
  localparam logic [31:0] OUTPORT_ADDR = 32'h8000_0004;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31];
  endfunction

endpackage

// File: rtl/dmem_arb.sv
// Shares the data-memory port between the core (priority) and a host agent,
// with bounded host wait and a lock mode that freezes the core.
module dmem_arb
  import nanorv32_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          reset_l,
  // core side
  input  logic          cpu_rd_req,
  input  logic [AW-1:0] cpu_rd_addr,
  input  logic          cpu_wr_req,
  input  logic [AW-1:0] cpu_wr_addr,
  input  logic [31:0]   cpu_wr_data,
  input  logic [3:0]    cpu_wr_be,
  output logic [31:0]   cpu_rd_data,
  output logic          stall,
  // host side
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  input  logic [3:0]    host_be,
  input  logic          host_lock,
  output logic          host_ack,
  output logic [31:0]   host_rdata,
  output logic          host_locked,
  // memory side
  output logic          mem_rd_req,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [31:0]   mem_rd_data,
  output logic          mem_wr_req,
  output logic [AW-1:0] mem_wr_addr,
  output logic [31:0]   mem_wr_data,
  output logic [3:0]    mem_wr_be
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAXWAIT);

  arb_state_t        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              ack_we;
  logic              core_req;
  logic              host_win;

  // Grant decision, next state and wait counter.
  // host_ack blocks a regrant of the same held request in the LOCKED ack cycle.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    core_req  = cpu_rd_req | cpu_wr_req;
    host_win  = host_req && (state != ARB_HPEND) && !host_ack &&
                ((state == ARB_LOCKED) || !core_req || (wait_cnt == WAIT_MAX));
    stall     = (host_win && core_req) || (state == ARB_LOCKED);

    if (!host_req || host_win) begin
      wait_nxt = '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_nxt = wait_cnt + WAIT_W'(1);
    end

    case (state)
      ARB_IDLE: begin
        if (host_win) begin
          state_nxt = ARB_HPEND;
        end else if (host_lock && !host_req) begin
          state_nxt = ARB_LOCKED;
        end
      end
      ARB_HPEND:  state_nxt = ARB_IDLE;
      ARB_LOCKED: begin
        if (!host_lock && !host_win) begin
          state_nxt = ARB_IDLE;
        end
      end
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  // Memory port mux: host when granted, otherwise core gated by stall.
  always_comb begin
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    mem_wr_req  = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_wr_be   = '0;
    if (host_win) begin
      if (host_we) begin
        mem_wr_req  = 1'b1;
        mem_wr_addr = host_addr;
        mem_wr_data = host_wdata;
        mem_wr_be   = host_be;
      end else begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = host_addr;
      end
    end else if (!stall) begin
      mem_rd_req  = cpu_rd_req;
      mem_rd_addr = cpu_rd_addr;
      mem_wr_req  = cpu_wr_req;
      mem_wr_addr = cpu_wr_addr;
      mem_wr_data = cpu_wr_data;
      mem_wr_be   = cpu_wr_be;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= ARB_IDLE;
      wait_cnt <= '0;
      host_ack <= 1'b0;
      ack_we   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      host_ack <= host_win;
      if (host_win) begin
        ack_we <= host_we;
      end
    end
  end

  // RAM data arrives in the ack cycle, so read data is steered, not stored.
  assign host_rdata  = (host_ack && !ack_we) ? mem_rd_data : 32'h0;
  assign host_locked = (state == ARB_LOCKED);
  assign cpu_rd_data = mem_rd_data;

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb: cycle vectors plus lock, HPEND-lock and reset sequences.
module tb_dmem_arb;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          reset_l;
  logic          cpu_rd_req, cpu_wr_req;
  logic [AW-1:0] cpu_rd_addr, cpu_wr_addr;
  logic [31:0]   cpu_wr_data, cpu_rd_data;
  logic [3:0]    cpu_wr_be;
  logic          stall;
  logic          host_req, host_we, host_lock, host_ack, host_locked;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata, host_rdata;
  logic [3:0]    host_be;
  logic          mem_rd_req, mem_wr_req;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [31:0]   mem_rd_data, mem_wr_data;
  logic [3:0]    mem_wr_be;

  logic [31:0] ram [256];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arb #(.AW(AW), .MAXWAIT(4)) dut (
    .clk(clk), .reset_l(reset_l),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_wr_be(cpu_wr_be),
    .cpu_rd_data(cpu_rd_data), .stall(stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_be(host_be), .host_lock(host_lock),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_locked(host_locked),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be)
  );

  // Byte-lane RAM with one-cycle read latency; read returns pre-write contents.
  always @(posedge clk) begin
    if (mem_rd_req) mem_rd_data <= ram[mem_rd_addr[9:2]];
    if (mem_wr_req) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wr_be[b]) ram[mem_wr_addr[9:2]][8*b +: 8] = mem_wr_data[8*b +: 8];
      end
    end
  end

  typedef struct {
    string       name;
    logic        rd;
    logic [31:0] ra;
    logic        wr;
    logic [31:0] wa, wd;
    logic        hreq, hwe;
    logic [31:0] ha, hd;
    logic        e_stall, e_ack;
    logic        e_mrd;
    logic [31:0] e_mra;
    logic        e_mwr;
    logic [31:0] e_mwa, e_mwd;
    logic [31:0] e_hrd;
    logic        ck_cpu;
    logic [31:0] e_cpu;
  } vec_t;

  function automatic vec_t v(string n, logic rd, logic [31:0] ra, logic wr, logic [31:0] wa,
                             logic [31:0] wd, logic hreq, logic hwe, logic [31:0] ha,
                             logic [31:0] hd, logic es, logic ea, logic emr, logic [31:0] emra,
                             logic emw, logic [31:0] emwa, logic [31:0] emwd, logic [31:0] ehr,
                             logic ckc, logic [31:0] ecpu);
    vec_t t;
    t.name = n; t.rd = rd; t.ra = ra; t.wr = wr; t.wa = wa; t.wd = wd;
    t.hreq = hreq; t.hwe = hwe; t.ha = ha; t.hd = hd;
    t.e_stall = es; t.e_ack = ea; t.e_mrd = emr; t.e_mra = emra;
    t.e_mwr = emw; t.e_mwa = emwa; t.e_mwd = emwd; t.e_hrd = ehr;
    t.ck_cpu = ckc; t.e_cpu = ecpu;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core(input logic rd, input logic [31:0] ra, input logic wr,
                      input logic [31:0] wa, input logic [31:0] wd);
    cpu_rd_req = rd; cpu_rd_addr = ra; cpu_wr_req = wr;
    cpu_wr_addr = wa; cpu_wr_data = wd; cpu_wr_be = 4'hF;
  endtask

  task automatic host(input logic req, input logic we, input logic [31:0] a,
                      input logic [31:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d; host_be = 4'hF;
  endtask

  task automatic chk_ctl(input string name, input logic es, input logic el, input logic ea,
                         input logic emr, input logic emw);
    #1;
    chk({name, ".stall"}, 32'(stall), 32'(es));
    chk({name, ".locked"}, 32'(host_locked), 32'(el));
    chk({name, ".ack"}, 32'(host_ack), 32'(ea));
    chk({name, ".mrd"}, 32'(mem_rd_req), 32'(emr));
    chk({name, ".mwr"}, 32'(mem_wr_req), 32'(emw));
  endtask

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[32'h40 >> 2] = 32'h1111_0040;
    ram[32'h44 >> 2] = 32'h2222_0044;
    ram[32'h48 >> 2] = 32'h3333_0048;
    mem_rd_data = 32'h0;
    reset_l = 1'b0;
    host_lock = 1'b0;
    core(0, 0, 0, 0, 0);
    host(0, 0, 0, 0);

    //              name           rd ra     wr wa     wd            hq we ha     hd            st ak mr mra    mw mwa    mwd           hrd           ck cpu
    vecs.push_back(v("hwr_grant",  0, 0,     0, 0,     0,            1, 1, 32'h10, 32'hA5A50001, 0, 0, 0, 0,     1, 32'h10, 32'hA5A50001, 0,            0, 0));
    vecs.push_back(v("hwr_ack",    0, 0,     0, 0,     0,            1, 1, 32'h10, 32'hA5A50001, 0, 1, 0, 0,     0, 0,      0,            0,            0, 0));
    vecs.push_back(v("hrd_grant",  0, 0,     0, 0,     0,            1, 0, 32'h10, 0,            0, 0, 1, 32'h10,0, 0,      0,            0,            0, 0));
    vecs.push_back(v("hrd_ack",    0, 0,     0, 0,     0,            1, 0, 32'h10, 0,            0, 1, 0, 0,     0, 0,      0,            32'hA5A50001, 0, 0));
    vecs.push_back(v("idle",       0, 0,     0, 0,     0,            0, 0, 0,      0,            0, 0, 0, 0,     0, 0,      0,            0,            0, 0));
    vecs.push_back(v("deny0",      1, 32'h40,0, 0,     0,            1, 0, 32'h44, 0,            0, 0, 1, 32'h40,0, 0,      0,            0,            0, 0));
    vecs.push_back(v("deny1",      1, 32'h40,0, 0,     0,            1, 0, 32'h44, 0,            0, 0, 1, 32'h40,0, 0,      0,            0,            1, 32'h11110040));
    vecs.push_back(v("deny2",      1, 32'h40,0, 0,     0,            1, 0, 32'h44, 0,            0, 0, 1, 32'h40,0, 0,      0,            0,            1, 32'h11110040));
    vecs.push_back(v("deny3",      1, 32'h48,0, 0,     0,            1, 0, 32'h44, 0,            0, 0, 1, 32'h48,0, 0,      0,            0,            1, 32'h11110040));
    vecs.push_back(v("host_wins",  1, 32'h40,0, 0,     0,            1, 0, 32'h44, 0,            1, 0, 1, 32'h44,0, 0,      0,            0,            1, 32'h33330048));
    vecs.push_back(v("hack_core",  1, 32'h40,0, 0,     0,            1, 0, 32'h44, 0,            0, 1, 1, 32'h40,0, 0,      0,            32'h22220044, 0, 0));
    vecs.push_back(v("core_after", 1, 32'h40,0, 0,     0,            0, 0, 0,      0,            0, 0, 1, 32'h40,0, 0,      0,            0,            1, 32'h11110040));
    vecs.push_back(v("cw_first",   0, 0,     1, 32'h20,32'hC0DE0020, 1, 0, 32'h20, 0,            0, 0, 0, 0,     1, 32'h20, 32'hC0DE0020, 0,            0, 0));
    vecs.push_back(v("cw_hgrant",  0, 0,     0, 0,     0,            1, 0, 32'h20, 0,            0, 0, 1, 32'h20,0, 0,      0,            0,            0, 0));
    vecs.push_back(v("cw_hack",    0, 0,     0, 0,     0,            1, 0, 32'h20, 0,            0, 1, 0, 0,     0, 0,      0,            32'hC0DE0020, 0, 0));
    vecs.push_back(v("idle2",      0, 0,     0, 0,     0,            0, 0, 0,      0,            0, 0, 0, 0,     0, 0,      0,            0,            0, 0));

    // Reset values
    #12;
    chk_ctl("reset", 0, 0, 0, 0, 0);
    chk("reset.hrdata", host_rdata, 32'h0);
    reset_l = 1'b1;
    step();

    foreach (vecs[i]) begin
      core(vecs[i].rd, vecs[i].ra, vecs[i].wr, vecs[i].wa, vecs[i].wd);
      host(vecs[i].hreq, vecs[i].hwe, vecs[i].ha, vecs[i].hd);
      #1;
      chk({vecs[i].name, ".stall"}, 32'(stall), 32'(vecs[i].e_stall));
      chk({vecs[i].name, ".ack"}, 32'(host_ack), 32'(vecs[i].e_ack));
      chk({vecs[i].name, ".locked"}, 32'(host_locked), 32'h0);
      chk({vecs[i].name, ".mrd"}, 32'(mem_rd_req), 32'(vecs[i].e_mrd));
      chk({vecs[i].name, ".mwr"}, 32'(mem_wr_req), 32'(vecs[i].e_mwr));
      chk({vecs[i].name, ".hrdata"}, host_rdata, vecs[i].e_hrd);
      if (vecs[i].e_mrd) chk({vecs[i].name, ".mra"}, mem_rd_addr, vecs[i].e_mra);
      if (vecs[i].e_mwr) begin
        chk({vecs[i].name, ".mwa"}, mem_wr_addr, vecs[i].e_mwa);
        chk({vecs[i].name, ".mwd"}, mem_wr_data, vecs[i].e_mwd);
      end
      if (vecs[i].ck_cpu) chk({vecs[i].name, ".cpu_rd"}, cpu_rd_data, vecs[i].e_cpu);
      step();
    end

    // Lock: 8 back-to-back host writes with the core frozen
    host_lock = 1'b1;
    chk_ctl("lock_req", 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      core(1, 32'h40, 0, 0, 0);
      host(1, 1, 32'h80 + 32'(4 * i), 32'h5A00_0000 + 32'(i));
      chk_ctl("lock_grant", 1, 1, 0, 0, 1);
      chk("lock_grant.mwa", mem_wr_addr, 32'h80 + 32'(4 * i));
      chk("lock_grant.mwd", mem_wr_data, 32'h5A00_0000 + 32'(i));
      step();
      chk_ctl("lock_ack", 1, 1, 1, 0, 0);
      step();
    end
    host_lock = 1'b0;
    host(0, 0, 0, 0);
    chk_ctl("unlock", 1, 1, 0, 0, 0);
    step();
    chk_ctl("unlocked", 0, 0, 0, 1, 0);
    chk("unlocked.mra", mem_rd_addr, 32'h40);
    step();
    core(0, 0, 0, 0, 0);
    host(1, 0, 32'h8C, 0);
    chk_ctl("rb_grant", 0, 0, 0, 1, 0);
    step();
    chk_ctl("rb_ack", 0, 0, 1, 0, 0);
    chk("rb_ack.hrdata", host_rdata, 32'h5A00_0003);
    step();

    // Lock raised during HPEND is taken after the ack
    host(1, 1, 32'h90, 32'h0000_9090);
    chk_ctl("hp_grant", 0, 0, 0, 0, 1);
    step();
    host_lock = 1'b1;
    chk_ctl("hp_ack", 0, 0, 1, 0, 0);
    step();
    host(0, 0, 0, 0);
    chk_ctl("hp_idle", 0, 0, 0, 0, 0);
    step();
    chk_ctl("hp_locked", 1, 1, 0, 0, 0);
    host_lock = 1'b0;
    step();
    chk_ctl("hp_unlocked", 0, 0, 0, 0, 0);

    // Reset across a grant edge: the pending ack is dropped
    host(1, 1, 32'h94, 32'h0000_9494);
    chk_ctl("rst_grant", 0, 0, 0, 0, 1);
    reset_l = 1'b0;
    step();
    host(0, 0, 0, 0);
    reset_l = 1'b1;
    chk_ctl("rst_noack0", 0, 0, 0, 0, 0);
    step();
    chk_ctl("rst_noack1", 0, 0, 0, 0, 0);

    // Asynchronous reset while LOCKED
    host_lock = 1'b1;
    step();
    chk_ctl("rl_locked", 1, 1, 0, 0, 0);
    #2;
    reset_l = 1'b0;
    chk_ctl("rl_async", 0, 0, 0, 0, 0);
    host_lock = 1'b0;
    #2;
    reset_l = 1'b1;
    step();
    chk_ctl("rl_after", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
